// File: rtl/fp_add_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : fp_add_arbiter
// Description : Round-robin arbiter/sequencer sharing one single-precision
//               floating-point adder among NUM_REQ requesters. One operand
//               pair is accepted at a time (valid/ready), held on the adder
//               inputs until the adder finishes or a timeout expires, and the
//               captured sum and flags are returned to the winning requester
//               through a response handshake.
// Ports       : clk, rst_n           - clock, asynchronous active-low reset
//               req_valid/req_ready  - per-requester operand handshake
//               req_a/req_b          - packed operands, requester i at [32i+:32]
//               rsp_valid/rsp_ready  - per-requester result handshake
//               rsp_sum, rsp_*flags  - captured result (shared bus)
//               adder_a/adder_b      - operands held towards the adder
//               adder_sum/finish/... - adder result and status
//               busy                 - high whenever not idle
//               grant_id             - index of current or last owner
// Revision    : 1.0 - initial release
// ============================================================================
module fp_add_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int ADDER_WAIT = 2,
    parameter int TIMEOUT    = 15
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [32*NUM_REQ-1:0]      req_a,
    input  logic [32*NUM_REQ-1:0]      req_b,
    output logic [NUM_REQ-1:0]         rsp_valid,
    input  logic [NUM_REQ-1:0]         rsp_ready,
    output logic [31:0]                rsp_sum,
    output logic                       rsp_overflow,
    output logic                       rsp_underflow,
    output logic                       rsp_timeout,
    output logic [31:0]                adder_a,
    output logic [31:0]                adder_b,
    input  logic [31:0]                adder_sum,
    input  logic                       adder_finish,
    input  logic                       adder_overflow,
    input  logic                       adder_underflow,
    output logic                       busy,
    output logic [$clog2(NUM_REQ)-1:0] grant_id
);

    localparam int         ID_W    = $clog2(NUM_REQ);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;
    localparam logic [7:0] CNT_MIN = 8'(ADDER_WAIT);
    localparam logic [7:0] CNT_MAX = 8'(TIMEOUT);

    logic [1:0]         state;
    logic [1:0]         next_state;
    logic [ID_W-1:0]    last_grant;
    logic [ID_W-1:0]    pick_id;
    logic               pick_found;
    int                 rr_idx;
    logic [7:0]         wait_cnt;
    logic [31:0]        opa_arr [NUM_REQ];
    logic [31:0]        opb_arr [NUM_REQ];
    logic [NUM_REQ-1:0] grant_onehot;
    logic               accept;
    logic               capture;
    logic               release_rsp;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign opa_arr[gi] = req_a[32*gi +: 32];
            assign opb_arr[gi] = req_b[32*gi +: 32];
        end
    endgenerate

    // Round-robin search starting one past the last served requester, so the
    // previous owner has the lowest priority on the next arbitration.
    always_comb begin
        pick_found = 1'b0;
        pick_id    = '0;
        rr_idx     = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            rr_idx = int'(last_grant) + k;
            if (rr_idx >= NUM_REQ) begin
                rr_idx = rr_idx - NUM_REQ;
            end
            if (!pick_found && req_valid[ID_W'(rr_idx)]) begin
                pick_found = 1'b1;
                pick_id    = ID_W'(rr_idx);
            end
        end
    end

    assign grant_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_id;

    // Capture on a finished result once the minimum hold has elapsed, or
    // unconditionally when the wait budget is exhausted.
    assign accept      = (state == ST_IDLE) && pick_found;
    assign capture     = (state == ST_WAIT) &&
                         (((wait_cnt >= CNT_MIN) && adder_finish) || (wait_cnt == CNT_MAX));
    assign release_rsp = (state == ST_RESP) && rsp_ready[grant_id];

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: if (accept)      next_state = ST_WAIT;
            ST_WAIT: if (capture)     next_state = ST_RESP;
            ST_RESP: if (release_rsp) next_state = ST_IDLE;
            default:                  next_state = ST_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        req_ready = '0;
        if (accept) begin
            req_ready[pick_id] = 1'b1;
        end
        busy = (state != ST_IDLE);
    end

    // Datapath: operand hold, wait counter, result capture, ownership
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            adder_a       <= '0;
            adder_b       <= '0;
            grant_id      <= '0;
            last_grant    <= ID_W'(NUM_REQ - 1);
            wait_cnt      <= '0;
            rsp_valid     <= '0;
            rsp_sum       <= '0;
            rsp_overflow  <= 1'b0;
            rsp_underflow <= 1'b0;
            rsp_timeout   <= 1'b0;
        end else begin
            if (accept) begin
                adder_a  <= opa_arr[pick_id];
                adder_b  <= opb_arr[pick_id];
                grant_id <= pick_id;
                wait_cnt <= 8'd1;
            end else if (state == ST_WAIT) begin
                wait_cnt <= wait_cnt + 8'd1;
            end

            if (capture) begin
                rsp_sum       <= adder_sum;
                rsp_overflow  <= adder_overflow;
                rsp_underflow <= adder_underflow;
                rsp_timeout   <= ~adder_finish;
                rsp_valid     <= grant_onehot;
            end

            if (release_rsp) begin
                rsp_valid  <= '0;
                last_grant <= grant_id;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fp_add_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_fp_add_arbiter
// Description : Self-checking bench for fp_add_arbiter. A behavioural adder
//               model produces a sum that depends on the held operands and on
//               how long they have been held, so the capture cycle shows up in
//               the returned sum. Expected grants, latencies and results come
//               from a round-robin/latency reference model kept here.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fp_add_arbiter;

    localparam int N  = 4;
    localparam int AW = 2;
    localparam int TO = 15;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [32*N-1:0] req_a;
    logic [32*N-1:0] req_b;
    logic [N-1:0]    rsp_valid;
    logic [N-1:0]    rsp_ready;
    logic [31:0]     rsp_sum;
    logic            rsp_overflow;
    logic            rsp_underflow;
    logic            rsp_timeout;
    logic [31:0]     adder_a;
    logic [31:0]     adder_b;
    logic [31:0]     adder_sum;
    logic            adder_finish;
    logic            adder_overflow;
    logic            adder_underflow;
    logic            busy;
    logic [1:0]      grant_id;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fp_add_arbiter #(
        .NUM_REQ    (N),
        .ADDER_WAIT (AW),
        .TIMEOUT    (TO)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_a           (req_a),
        .req_b           (req_b),
        .rsp_valid       (rsp_valid),
        .rsp_ready       (rsp_ready),
        .rsp_sum         (rsp_sum),
        .rsp_overflow    (rsp_overflow),
        .rsp_underflow   (rsp_underflow),
        .rsp_timeout     (rsp_timeout),
        .adder_a         (adder_a),
        .adder_b         (adder_b),
        .adder_sum       (adder_sum),
        .adder_finish    (adder_finish),
        .adder_overflow  (adder_overflow),
        .adder_underflow (adder_underflow),
        .busy            (busy),
        .grant_id        (grant_id)
    );

    // ---------------- adder model ----------------
    int          age = 0;
    int          fin_delay = 2;
    bit          fin_en = 1'b0;
    bit          force_en = 1'b0;
    logic [31:0] force_val = '0;
    logic        ovf_m = 1'b0;
    logic        unf_m = 1'b0;

    function automatic logic [31:0] mix(input logic [31:0] a, input logic [31:0] b);
        return (a ^ {b[15:0], b[31:16]}) + 32'h9E37_79B9;
    endfunction

    // age = number of cycles the operands have been held for the current op
    always @(negedge clk) begin
        if (busy && rsp_valid == '0) age <= age + 1;
        else                         age <= 0;
    end

    assign adder_finish    = fin_en && (age >= fin_delay);
    assign adder_sum       = force_en ? force_val : (mix(adder_a, adder_b) ^ {24'h0, age[7:0]});
    assign adder_overflow  = ovf_m;
    assign adder_underflow = unf_m;

    // ---------------- reference model state ----------------
    int          last_g = N - 1;
    logic [31:0] opa [N];
    logic [31:0] opb [N];

    function automatic int rr_pick(input int last, input logic [N-1:0] m);
        for (int k = 1; k <= N; k++) begin
            int i;
            i = (last + k) % N;
            if (m[i]) return i;
        end
        return -1;
    endfunction

    // One complete transaction, called at a falling edge with the DUT idle.
    task automatic do_op(input logic [N-1:0] mask, input int d, input bit fen,
                         input bit fforce, input logic [31:0] fval,
                         input bit ovf, input bit unf, input int hold, input string tag);
        int          w;
        int          exp_c;
        int          n;
        bit          exp_to;
        logic [31:0] exp_sum;
        logic [N-1:0] oh;
        w  = rr_pick(last_g, mask);
        oh = '0;
        oh[w] = 1'b1;
        if (fen && d <= TO) begin
            exp_c  = (d > AW) ? d : AW;
            exp_to = 1'b0;
        end else begin
            exp_c  = TO;
            exp_to = 1'b1;
        end
        exp_sum = fforce ? fval : (mix(opa[w], opb[w]) ^ {24'h0, exp_c[7:0]});

        fin_delay = d; fin_en = fen; force_en = fforce; force_val = fval;
        ovf_m = ovf; unf_m = unf;
        for (int i = 0; i < N; i++) begin
            req_a[32*i +: 32] = opa[i];
            req_b[32*i +: 32] = opb[i];
        end
        req_valid = mask;
        rsp_ready = (hold == 0) ? '1 : '0;
        #1;
        checks++;
        if (req_ready !== oh) begin
            errors++;
            $display("FAIL %s grant: req_ready=%b expected %b", tag, req_ready, oh);
        end
        @(posedge clk); #1;
        checks++;
        if (grant_id !== 2'(w) || adder_a !== opa[w] || adder_b !== opb[w] || busy !== 1'b1) begin
            errors++;
            $display("FAIL %s accept: grant_id=%0d a=%h b=%h busy=%b expected %0d %h %h 1",
                     tag, grant_id, adder_a, adder_b, busy, w, opa[w], opb[w]);
        end
        n = 0;
        while (n < TO + 4) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (rsp_valid !== '0) break;
        end
        checks++;
        if (n != exp_c) begin
            errors++;
            $display("FAIL %s latency: %0d cycles expected %0d", tag, n, exp_c);
        end
        checks++;
        if (rsp_valid !== oh || adder_a !== opa[w] || adder_b !== opb[w]) begin
            errors++;
            $display("FAIL %s route: rsp_valid=%b a=%h expected %b %h", tag, rsp_valid, adder_a, oh, opa[w]);
        end
        checks++;
        if ({rsp_sum, rsp_overflow, rsp_underflow, rsp_timeout} !== {exp_sum, ovf, unf, exp_to}) begin
            errors++;
            $display("FAIL %s result: sum=%h ovf=%b unf=%b to=%b expected %h %b %b %b",
                     tag, rsp_sum, rsp_overflow, rsp_underflow, rsp_timeout, exp_sum, ovf, unf, exp_to);
        end
        for (int h = 0; h < hold; h++) begin
            rsp_ready    = N'($urandom);
            rsp_ready[w] = 1'b0;
            #1;
            checks++;
            if (rsp_valid !== oh || rsp_sum !== exp_sum || rsp_timeout !== exp_to ||
                rsp_overflow !== ovf || req_ready !== '0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL %s hold: rsp_valid=%b sum=%h to=%b req_ready=%b expected %b %h %b 0000",
                         tag, rsp_valid, rsp_sum, rsp_timeout, req_ready, oh, exp_sum, exp_to);
            end
            @(negedge clk);
        end
        rsp_ready    = N'($urandom);
        rsp_ready[w] = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (rsp_valid !== '0 || busy !== 1'b0 || rsp_sum !== exp_sum) begin
            errors++;
            $display("FAIL %s release: rsp_valid=%b busy=%b sum=%h expected 0000 0 %h",
                     tag, rsp_valid, busy, rsp_sum, exp_sum);
        end
        last_g = w;
        opa[w] = $urandom;
        opb[w] = $urandom;
        @(negedge clk);
        rsp_ready = '0;
        req_valid = '0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        req_valid = '0; rsp_ready = '0; req_a = '0; req_b = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({req_ready, rsp_valid, busy, grant_id, adder_a, adder_b} !== '0 ||
            {rsp_sum, rsp_overflow, rsp_underflow, rsp_timeout} !== '0) begin
            errors++;
            $display("FAIL reset: req_ready=%b rsp_valid=%b busy=%b gid=%0d a=%h sum=%h expected all 0",
                     req_ready, rsp_valid, busy, grant_id, adder_a, rsp_sum);
        end
        @(negedge clk);
        rst_n  = 1'b1;
        last_g = N - 1;
        @(negedge clk);
    endtask

    task automatic test_round_robin();
        for (int k = 0; k < 5; k++) do_op(4'hF, AW, 1'b1, 1'b0, '0, 1'b0, 1'b0, 0, "rr_all");
        do_op(4'b1010, 1, 1'b1, 1'b0, '0, 1'b0, 1'b0, 0, "rr_sparse");
        do_op(4'b1010, 4, 1'b1, 1'b0, '0, 1'b0, 1'b1, 0, "rr_sparse");
    endtask

    task automatic test_single();
        opa[2] = 32'h3F80_0000;
        opb[2] = 32'h4000_0000;
        do_op(4'b0100, 2, 1'b1, 1'b1, 32'h4040_0000, 1'b0, 1'b0, 0, "single");
    endtask

    task automatic test_timeout();
        do_op(4'b0010, 0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 0, "timeout_nofin");
        do_op(4'b0001, TO, 1'b1, 1'b0, '0, 1'b0, 1'b0, 0, "finish_at_limit");
        do_op(4'b0001, TO + 1, 1'b1, 1'b0, '0, 1'b0, 1'b0, 0, "finish_late");
    endtask

    task automatic test_resp_hold();
        do_op(4'hF, AW, 1'b1, 1'b0, '0, 1'b1, 1'b1, 5, "resp_hold");
    endtask

    task automatic test_overflow();
        do_op(4'b1000, 3, 1'b1, 1'b1, 32'h7F80_0000, 1'b1, 1'b0, 0, "overflow");
        do_op(4'b0110, AW, 1'b1, 1'b0, '0, 1'b0, 1'b1, 1, "underflow");
    endtask

    task automatic test_reset_in_wait();
        bit stale;
        fin_en = 1'b0;
        for (int i = 0; i < N; i++) begin
            req_a[32*i +: 32] = opa[i];
            req_b[32*i +: 32] = opb[i];
        end
        req_valid = 4'b0100;
        @(posedge clk);
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({req_ready, rsp_valid, busy, grant_id, adder_a, adder_b} !== '0 ||
            {rsp_sum, rsp_overflow, rsp_underflow, rsp_timeout} !== '0) begin
            errors++;
            $display("FAIL reset_in_wait: busy=%b gid=%0d a=%h rsp_valid=%b sum=%h expected all 0",
                     busy, grant_id, adder_a, rsp_valid, rsp_sum);
        end
        @(negedge clk);
        rst_n  = 1'b1;
        last_g = N - 1;
        stale  = 1'b0;
        for (int c = 0; c < TO + 5; c++) begin
            @(negedge clk);
            if (rsp_valid !== '0 || busy !== 1'b0) stale = 1'b1;
        end
        checks++;
        if (stale) begin
            errors++;
            $display("FAIL reset_stale: response or busy after reset, rsp_valid=%b busy=%b expected 0", rsp_valid, busy);
        end
        do_op(4'hF, AW, 1'b1, 1'b0, '0, 1'b0, 1'b0, 0, "post_reset");
    endtask

    task automatic test_random();
        for (int k = 0; k < 30; k++) begin
            logic [N-1:0] m;
            m = N'($urandom_range(1, (1 << N) - 1));
            do_op(m, $urandom_range(1, TO + 3), bit'($urandom_range(0, 3) != 0), 1'b0, '0,
                  bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
                  $urandom_range(0, 3), "random");
        end
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            opa[i] = $urandom;
            opb[i] = $urandom;
        end
        test_reset();
        test_round_robin();
        test_single();
        test_timeout();
        test_resp_hold();
        test_overflow();
        test_reset_in_wait();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
